gate_vector_checker: RTL and testbench



---
 rtl/gate_vector_checker.sv | 159 +++++++++++++++
 tb/tb_gate_vector_checker.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/gate_vector_checker.sv
`timescale 1ns/1ps
// On-chip response checker for a 2-input gate: walks {a,b} through 00..11,
// compares each settled response against TRUTH and reports count/first-fail/pass.
module gate_vector_checker #(
    parameter logic [3:0] TRUTH  = 4'b1110,
    parameter int         SETTLE = 1,
    parameter bit         SYNC   = 1'b0,
    parameter int         ERR_W  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a,
    output logic             b,
    input  logic             y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic             fail_valid,
    output logic [1:0]       fail_vec
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    generate
        if (SETTLE < 1 || (SYNC && SETTLE < 3)) begin : g_param_check
            $error("gate_vector_checker: SETTLE must be >=1, and >=3 when SYNC=1");
        end
    endgenerate

    logic [1:0]       state_q, state_d;
    logic [1:0]       vec_q, vec_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             fval_q, fval_d;
    logic [1:0]       fvec_q, fvec_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             y_s;

    // The synchronizer needs two of the settle cycles to deliver a fresh y.
    generate
        if (SYNC) begin : g_sync
            logic sync1_q, sync2_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                end else begin
                    sync1_q <= y;
                    sync2_q <= sync1_q;
                end
            end
            assign y_s = sync2_q;
        end else begin : g_nosync
            assign y_s = y;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        fval_d  = fval_q;
        fvec_d  = fvec_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_SETTLE;
                    vec_d   = 2'd0;
                    cnt_d   = '0;
                    err_d   = '0;
                    fval_d  = 1'b0;
                    fvec_d  = 2'd0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            S_SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SAMPLE: begin
                if (y_s != TRUTH[vec_q]) begin
                    if (err_q != ERR_MAX) begin
                        err_d = err_q + 1'b1;
                    end
                    if (!fval_q) begin
                        fval_d = 1'b1;
                        fvec_d = vec_q;
                    end
                end
                if (vec_q == 2'd3) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                end else begin
                    state_d = S_SETTLE;
                    vec_d   = vec_q + 2'd1;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            vec_q   <= 2'd0;
            cnt_q   <= '0;
            err_q   <= '0;
            fval_q  <= 1'b0;
            fvec_q  <= 2'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fval_q  <= fval_d;
            fvec_q  <= fvec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    // The vector register doubles as the stimulus, so {a,b} ends at 11.
    assign a          = vec_q[1];
    assign b          = vec_q[0];
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_cnt    = err_q;
    assign fail_valid = fval_q;
    assign fail_vec   = fvec_q;

endmodule

// File: tb/tb_gate_vector_checker.sv
`timescale 1ns/1ps
// Directed bench for gate_vector_checker: four differently parameterised
// checkers driven by a modelled gate (a|b, stuck-0 or ~(a|b)).
module tb_gate_vector_checker;

    typedef struct {
        int       inst;
        int       mode;
        int       expErr;
        bit       expFval;
        bit [1:0] expFvec;
        bit       expPass;
        int       expEdge;
    } vecRec_t;

    logic       clk;
    logic       rst_n;
    logic       startV [4];
    logic       aV     [4];
    logic       bV     [4];
    logic       yV     [4];
    logic       busyV  [4];
    logic       doneV  [4];
    logic       passV  [4];
    logic       fvalV  [4];
    logic [1:0] fvecV  [4];
    logic [2:0] errV   [4];
    logic [2:0] err0, err1, err3;
    logic [0:0] err2;
    int         ymode;
    int         total;
    int         bad;
    vecRec_t    tbl [9];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gate under test model, selected by ymode.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            case (ymode)
                0:       yV[i] = aV[i] | bV[i];
                1:       yV[i] = 1'b0;
                default: yV[i] = ~(aV[i] | bV[i]);
            endcase
        end
    end

    always_comb begin
        errV[0] = err0;
        errV[1] = err1;
        errV[2] = {2'b00, err2};
        errV[3] = err3;
    end

    gate_vector_checker #(.TRUTH(4'b1110), .SETTLE(1), .SYNC(1'b0), .ERR_W(3)) u0 (
        .clk(clk), .rst_n(rst_n), .start(startV[0]), .a(aV[0]), .b(bV[0]), .y(yV[0]),
        .busy(busyV[0]), .done(doneV[0]), .pass(passV[0]), .err_cnt(err0),
        .fail_valid(fvalV[0]), .fail_vec(fvecV[0]));

    gate_vector_checker #(.TRUTH(4'b1000), .SETTLE(1), .SYNC(1'b0), .ERR_W(3)) u1 (
        .clk(clk), .rst_n(rst_n), .start(startV[1]), .a(aV[1]), .b(bV[1]), .y(yV[1]),
        .busy(busyV[1]), .done(doneV[1]), .pass(passV[1]), .err_cnt(err1),
        .fail_valid(fvalV[1]), .fail_vec(fvecV[1]));

    gate_vector_checker #(.TRUTH(4'b1110), .SETTLE(1), .SYNC(1'b0), .ERR_W(1)) u2 (
        .clk(clk), .rst_n(rst_n), .start(startV[2]), .a(aV[2]), .b(bV[2]), .y(yV[2]),
        .busy(busyV[2]), .done(doneV[2]), .pass(passV[2]), .err_cnt(err2),
        .fail_valid(fvalV[2]), .fail_vec(fvecV[2]));

    gate_vector_checker #(.TRUTH(4'b1110), .SETTLE(3), .SYNC(1'b1), .ERR_W(3)) u3 (
        .clk(clk), .rst_n(rst_n), .start(startV[3]), .a(aV[3]), .b(bV[3]), .y(yV[3]),
        .busy(busyV[3]), .done(doneV[3]), .pass(passV[3]), .err_cnt(err3),
        .fail_valid(fvalV[3]), .fail_vec(fvecV[3]));

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pulse start for one edge, then count edges until done (bounded).
    task automatic applyStimulus(input int inst, input int mode, output int edges);
        ymode = mode;
        @(negedge clk);
        startV[inst] = 1'b1;
        @(posedge clk);
        #1;
        startV[inst] = 1'b0;
        edges = 0;
        while (!doneV[inst] && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic checkResult(input string tag, input int inst, input int eErr, input int eFval,
                               input int eFvec, input int ePass);
        checkOutput({tag, ".err_cnt"}, int'(errV[inst]), eErr);
        checkOutput({tag, ".fail_valid"}, int'(fvalV[inst]), eFval);
        if (eFval != 0) checkOutput({tag, ".fail_vec"}, int'(fvecV[inst]), eFvec);
        checkOutput({tag, ".pass"}, int'(passV[inst]), ePass);
        checkOutput({tag, ".done"}, int'(doneV[inst]), 1);
    endtask

    initial begin
        int edges;
        total = 0;
        bad   = 0;
        ymode = 0;
        for (int i = 0; i < 4; i++) startV[i] = 1'b0;

        tbl[0] = '{0, 0, 0, 1'b0, 2'b00, 1'b1, 8};
        tbl[1] = '{0, 1, 3, 1'b1, 2'b01, 1'b0, 8};
        tbl[2] = '{0, 2, 4, 1'b1, 2'b00, 1'b0, 8};
        tbl[3] = '{1, 0, 2, 1'b1, 2'b01, 1'b0, 8};
        tbl[4] = '{1, 1, 1, 1'b1, 2'b11, 1'b0, 8};
        tbl[5] = '{2, 2, 1, 1'b1, 2'b00, 1'b0, 8};
        tbl[6] = '{2, 1, 1, 1'b1, 2'b01, 1'b0, 8};
        tbl[7] = '{3, 0, 0, 1'b0, 2'b00, 1'b1, 16};
        tbl[8] = '{3, 1, 3, 1'b1, 2'b01, 1'b0, 16};

        rst_n = 1'b0;
        #23;
        for (int i = 0; i < 4; i += 3) begin
            checkOutput($sformatf("reset%0d.ab", i), int'({aV[i], bV[i]}), 0);
            checkOutput($sformatf("reset%0d.busy", i), int'(busyV[i]), 0);
            checkOutput($sformatf("reset%0d.done", i), int'(doneV[i]), 0);
            checkOutput($sformatf("reset%0d.pass", i), int'(passV[i]), 0);
            checkOutput($sformatf("reset%0d.err", i), int'(errV[i]), 0);
            checkOutput($sformatf("reset%0d.fval", i), int'(fvalV[i]), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Stimulus sequence: {a,b} steps every two cycles, done at edge 8.
        ymode = 0;
        @(negedge clk);
        startV[0] = 1'b1;
        @(posedge clk);
        #1;
        startV[0] = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            checkOutput($sformatf("seq.ab@%0d", k), int'({aV[0], bV[0]}), (k >= 8) ? 3 : k / 2);
            checkOutput($sformatf("seq.busy@%0d", k), int'(busyV[0]), (k < 8) ? 1 : 0);
            checkOutput($sformatf("seq.done@%0d", k), int'(doneV[0]), (k == 8) ? 1 : 0);
            @(posedge clk);
            #1;
        end
        checkResult("seq", 0, 0, 0, 0, 1);

        // Table of complete runs across the four configurations.
        for (int r = 0; r < 9; r++) begin
            applyStimulus(tbl[r].inst, tbl[r].mode, edges);
            checkOutput($sformatf("tbl%0d.edge", r), edges, tbl[r].expEdge);
            checkResult($sformatf("tbl%0d", r), tbl[r].inst, tbl[r].expErr,
                        int'(tbl[r].expFval), int'(tbl[r].expFvec), int'(tbl[r].expPass));
        end

        // start re-pulsed while busy is ignored.
        ymode = 1;
        @(negedge clk);
        startV[0] = 1'b1;
        @(posedge clk);
        #1;
        startV[0] = 1'b0;
        edges = 0;
        while (!doneV[0] && edges < 200) begin
            startV[0] = (edges == 2 || edges == 4);
            @(posedge clk);
            #1;
            edges++;
        end
        startV[0] = 1'b0;
        checkOutput("rep.edge", edges, 8);
        checkResult("rep", 0, 3, 1, 1, 0);

        // start in DONE clears results on the accepting edge and reruns.
        @(negedge clk);
        startV[0] = 1'b1;
        @(posedge clk);
        #1;
        startV[0] = 1'b0;
        checkOutput("restart.done", int'(doneV[0]), 0);
        checkOutput("restart.busy", int'(busyV[0]), 1);
        checkOutput("restart.err", int'(errV[0]), 0);
        checkOutput("restart.fval", int'(fvalV[0]), 0);
        edges = 0;
        while (!doneV[0] && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
        end
        checkOutput("restart.edge", edges, 8);
        checkResult("restart", 0, 3, 1, 1, 0);

        // Asynchronous reset mid-run aborts immediately.
        ymode = 1;
        @(negedge clk);
        startV[0] = 1'b1;
        @(posedge clk);
        #1;
        startV[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("abort.pre_err", int'(errV[0]), 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort.ab", int'({aV[0], bV[0]}), 0);
        checkOutput("abort.busy", int'(busyV[0]), 0);
        checkOutput("abort.done", int'(doneV[0]), 0);
        checkOutput("abort.pass", int'(passV[0]), 0);
        checkOutput("abort.err", int'(errV[0]), 0);
        checkOutput("abort.fval", int'(fvalV[0]), 0);
        checkOutput("abort.fvec", int'(fvecV[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 0, edges);
        checkOutput("postreset.edge", edges, 8);
        checkResult("postreset", 0, 0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
